// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among num_cores_p cores.
// One transaction is outstanding at the memory at a time.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int num_cores_p = 4,
  parameter int id_width_p  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [num_cores_p-1:0]    req_valid_i,
  input  logic [num_cores_p-1:0]    req_wen_i,
  input  logic [num_cores_p-1:0]    req_byte_i,
  input  logic [32*num_cores_p-1:0] req_addr_i,
  input  logic [32*num_cores_p-1:0] req_wdata_i,
  output logic [num_cores_p-1:0]    req_yumi_o,
  output logic [num_cores_p-1:0]    resp_valid_o,
  output logic [31:0]               resp_data_o,
  input  logic [num_cores_p-1:0]    resp_yumi_i,
  output logic                      mem_valid_o,
  output logic                      mem_wen_o,
  output logic                      mem_byte_o,
  output logic [31:0]               mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  input  logic                      mem_yumi_i,
  input  logic                      mem_valid_i,
  input  logic [31:0]               mem_rdata_i,
  output logic                      mem_yumi_o,
  output logic                      busy_o,
  output logic [id_width_p-1:0]     owner_o
);

  // state | meaning
  // IDLE  | no transaction; pick a winner from rr_ptr upward
  // REQ   | latched request presented to memory, waiting for mem_yumi_i
  // RESP  | waiting for memory response and owner's consume
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_e;

  state_e                state_r, state_n;
  logic [id_width_p-1:0] owner_r, rr_ptr_r, winner;
  logic                  found;
  logic                  win_wen, win_byte;
  logic [31:0]           win_addr, win_wdata;
  logic                  wen_r, byte_r;
  logic [31:0]           addr_r, wdata_r;
  logic                  resp_phase, mem_done;
  int                    scan_idx;

  always_comb begin
    found     = 1'b0;
    winner    = '0;
    win_wen   = 1'b0;
    win_byte  = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    scan_idx  = 0;
    for (int i = 0; i < num_cores_p; i++) begin
      scan_idx = (int'(rr_ptr_r) + i) % num_cores_p;
      if (!found && req_valid_i[scan_idx]) begin
        found     = 1'b1;
        winner    = id_width_p'(scan_idx);
        win_wen   = req_wen_i[scan_idx];
        win_byte  = req_byte_i[scan_idx];
        win_addr  = req_addr_i[32*scan_idx +: 32];
        win_wdata = req_wdata_i[32*scan_idx +: 32];
      end
    end
  end

  // acceptance and response can coincide in REQ, so the response path is live there too
  assign resp_phase = (state_r == RESP) || ((state_r == REQ) && mem_yumi_i);
  assign mem_done   = resp_phase && mem_valid_i && resp_yumi_i[owner_r];

  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r  <= '0;
      rr_ptr_r <= '0;
      wen_r    <= 1'b0;
      byte_r   <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
    end else begin
      if ((state_r == IDLE) && found) begin
        owner_r <= winner;
        wen_r   <= win_wen;
        byte_r  <= win_byte;
        addr_r  <= win_addr;
        wdata_r <= win_wdata;
      end
      if (mem_done)
        rr_ptr_r <= (owner_r == id_width_p'(num_cores_p - 1)) ? '0 : owner_r + id_width_p'(1);
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (found) state_n = REQ;
      REQ:     if (mem_yumi_i) state_n = mem_done ? IDLE : RESP;
      RESP:    if (mem_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_yumi_o   = '0;
    resp_valid_o = '0;
    resp_data_o  = '0;
    mem_yumi_o   = 1'b0;
    if (state_r == REQ) req_yumi_o[owner_r] = mem_yumi_i;
    if (resp_phase) begin
      resp_valid_o[owner_r] = mem_valid_i;
      resp_data_o           = mem_rdata_i;
      mem_yumi_o            = mem_done;
    end
  end

  assign mem_valid_o = (state_r == REQ);
  assign mem_wen_o   = wen_r;
  assign mem_byte_o  = byte_r;
  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;
  assign busy_o      = (state_r != IDLE);
  assign owner_o     = owner_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected grants/responses are queued at
// stimulus time and a negedge monitor pops them on each memory handshake.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid_i, req_wen_i, req_byte_i, req_yumi_o;
  logic [N-1:0]   resp_valid_o, resp_yumi_i;
  logic [32*N-1:0] req_addr_i, req_wdata_i;
  logic [31:0]    resp_data_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic           mem_valid_o, mem_wen_o, mem_byte_o, mem_yumi_i, mem_valid_i;
  logic           mem_yumi_o, busy_o;
  logic [1:0]     owner_o;
  logic [110:0]   all_out;

  dmem_arbiter #(.num_cores_p(N), .id_width_p(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_wen_i(req_wen_i), .req_byte_i(req_byte_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_yumi_o(req_yumi_o),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
    .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_byte_o(mem_byte_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_yumi_i(mem_yumi_i),
    .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i), .mem_yumi_o(mem_yumi_o),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk = ~clk;

  assign all_out = {req_yumi_o, resp_valid_o, resp_data_o, mem_valid_o, mem_wen_o,
                    mem_byte_o, mem_addr_o, mem_wdata_o, mem_yumi_o, busy_o, owner_o};

  typedef struct {
    logic [1:0]  owner;
    logic [3:0]  onehot;
    logic        wen, byt;
    logic [31:0] addr, wdata;
  } grant_t;
  typedef struct {
    logic [3:0]  onehot;
    logic [31:0] data;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];
  grant_t mg;
  resp_t  mr;
  logic        c_wen[N], c_byte[N];
  logic [31:0] c_addr[N], c_wdata[N];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic settle(); @(negedge clk); endtask
  task automatic step();   @(posedge clk); #1; endtask

  task automatic set_req(input int c, input logic wen, input logic byt,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_valid_i[c] = 1'b1;
    req_wen_i[c]   = wen;
    req_byte_i[c]  = byt;
    req_addr_i[32*c +: 32]  = addr;
    req_wdata_i[32*c +: 32] = wdata;
    c_wen[c] = wen; c_byte[c] = byt; c_addr[c] = addr; c_wdata[c] = wdata;
  endtask

  task automatic push_grant(input int c);
    grant_t g;
    g.owner  = c[1:0];
    g.onehot = '0;
    g.onehot[c] = 1'b1;
    g.wen = c_wen[c]; g.byt = c_byte[c]; g.addr = c_addr[c]; g.wdata = c_wdata[c];
    gq.push_back(g);
  endtask

  task automatic push_resp(input int c, input logic [31:0] data);
    resp_t r;
    r.onehot = '0;
    r.onehot[c] = 1'b1;
    r.data = data;
    rq.push_back(r);
  endtask

  task automatic clear_mem();
    mem_yumi_i = 1'b0; mem_valid_i = 1'b0; mem_rdata_i = '0; resp_yumi_i = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid_i = '0; clear_mem();
    step(); step();
    reset = 1'b0;
  endtask

  // IDLE -> REQ (accepted at once) -> RESP (answered and consumed at once)
  task automatic do_txn(input int c, input logic [31:0] rdata, input bit keep);
    push_grant(c);
    push_resp(c, rdata);
    clear_mem();
    settle(); chk("txn_idle", {busy_o, mem_valid_o}, 2'b00); step();
    mem_yumi_i = 1'b1;
    settle(); chk("txn_req", {mem_valid_o, owner_o}, {1'b1, c[1:0]}); step();
    mem_yumi_i = 1'b0; mem_valid_i = 1'b1; mem_rdata_i = rdata; resp_yumi_i = '1;
    if (!keep) req_valid_i[c] = 1'b0;
    settle(); step();
    clear_mem();
  endtask

  always @(negedge clk) begin
    if (mem_valid_o && mem_yumi_i) begin
      if (gq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_accept: got owner %0d, expected no acceptance", owner_o);
      end else begin
        mg = gq.pop_front();
        chk("grant_owner", owner_o, mg.owner);
        chk("grant_yumi", req_yumi_o, mg.onehot);
        chk("grant_fields", {mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o},
            {mg.wen, mg.byt, mg.addr, mg.wdata});
      end
    end
    if (mem_yumi_o) begin
      if (rq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp: got resp_valid %b, expected none", resp_valid_o);
      end else begin
        mr = rq.pop_front();
        chk("resp_valid", resp_valid_o, mr.onehot);
        chk("resp_data", resp_data_o, mr.data);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid_i = '0; req_wen_i = '0; req_byte_i = '0;
    req_addr_i = '0; req_wdata_i = '0;
    for (int i = 0; i < N; i++) begin
      c_wen[i] = 1'b0; c_byte[i] = 1'b0; c_addr[i] = '0; c_wdata[i] = '0;
    end
    clear_mem();
    step();
    settle(); chk("reset_outputs", all_out, 0); step();
    reset = 1'b0;

    // single load from core 2
    set_req(2, 1'b0, 1'b0, 32'h40, 32'h0);
    push_grant(2); push_resp(2, 32'hDEADBEEF);
    settle(); chk("t1_lat0", mem_valid_o, 0); step();
    mem_yumi_i = 1'b1;
    settle(); chk("t1_lat1", mem_valid_o, 1); chk("t1_yumi", req_yumi_o, 4'b0100); step();
    mem_yumi_i = 1'b0; req_valid_i[2] = 1'b0;
    settle(); chk("t1_wait", {busy_o, resp_valid_o}, {1'b1, 4'b0000}); step();
    mem_valid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; resp_yumi_i = 4'b0100;
    settle(); chk("t1_data", resp_data_o, 32'hDEADBEEF); step();
    clear_mem();
    settle(); chk("t1_idle", {busy_o, mem_valid_o, resp_valid_o}, 0); step();

    // rr_ptr now 3: core 3 beats core 0
    set_req(0, 1'b0, 1'b0, 32'h00, 32'h0);
    set_req(3, 1'b1, 1'b0, 32'h33, 32'h3333);
    do_txn(3, 32'h0, 0);
    do_txn(0, 32'h1111, 0);

    // all four continuously from reset
    do_reset();
    for (int k = 0; k < N; k++)
      set_req(k, k[0], 1'b0, 32'h1000 + 32'(16 * k), 32'hC0DE0000 + 32'(k));
    do_txn(0, 32'hA0000000, 1);
    do_txn(1, 32'hA0000001, 1);
    do_txn(2, 32'hA0000002, 1);
    do_txn(3, 32'hA0000003, 1);
    do_txn(0, 32'hA0000004, 1);
    req_valid_i = '0;

    // store from core 1 with delayed memory acceptance (rr_ptr = 1)
    set_req(1, 1'b1, 1'b1, 32'h13, 32'h000000A5);
    push_grant(1); push_resp(1, 32'h0);
    settle(); step();
    for (int i = 0; i < 4; i++) begin
      mem_yumi_i = (i == 3);
      settle();
      chk("t3_valid", mem_valid_o, 1);
      chk("t3_fields", {mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o},
          {1'b1, 1'b1, 32'h13, 32'hA5});
      chk("t3_yumi", req_yumi_o, (i == 3) ? 4'b0010 : 4'b0000);
      step();
    end
    mem_yumi_i = 1'b0; req_valid_i[1] = 1'b0;
    mem_valid_i = 1'b1; mem_rdata_i = 32'h0; resp_yumi_i = 4'b0010;
    settle(); step();
    clear_mem();

    // REQ with yumi/valid/consume together (rr_ptr = 2 -> core 3, then core 0)
    set_req(3, 1'b0, 1'b0, 32'h300, 32'h0);
    set_req(0, 1'b0, 1'b1, 32'h4, 32'h0);
    push_grant(3); push_resp(3, 32'h12345678);
    settle(); step();
    mem_yumi_i = 1'b1; mem_valid_i = 1'b1; mem_rdata_i = 32'h12345678; resp_yumi_i = 4'b1000;
    settle(); chk("t4_pulse", {req_yumi_o, resp_valid_o, mem_yumi_o}, {4'b1000, 4'b1000, 1'b1}); step();
    clear_mem(); req_valid_i[3] = 1'b0;
    push_grant(0); push_resp(0, 32'h0BADF00D);
    settle(); chk("t4_idle", {busy_o, mem_valid_o}, 2'b00); step();
    mem_yumi_i = 1'b1;
    settle(); chk("t4_regrant", {mem_valid_o, owner_o}, {1'b1, 2'd0}); step();
    mem_yumi_i = 1'b0; req_valid_i[0] = 1'b0;
    mem_valid_i = 1'b1; mem_rdata_i = 32'h0BADF00D; resp_yumi_i = 4'b0001;
    settle(); step();
    clear_mem();

    // owner 1 withholds consume while core 2 waits (rr_ptr = 1)
    set_req(1, 1'b0, 1'b0, 32'h100, 32'h0);
    set_req(2, 1'b0, 1'b0, 32'h200, 32'h0);
    push_grant(1); push_resp(1, 32'h5555AAAA);
    settle(); step();
    mem_yumi_i = 1'b1;
    settle(); step();
    mem_yumi_i = 1'b0; req_valid_i[1] = 1'b0;
    mem_valid_i = 1'b1; mem_rdata_i = 32'h5555AAAA; resp_yumi_i = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t5_stall", {mem_yumi_o, resp_valid_o, mem_valid_o, owner_o, busy_o},
          {1'b0, 4'b0010, 1'b0, 2'd1, 1'b1});
      step();
    end
    resp_yumi_i = 4'b0010;
    settle(); chk("t5_done", mem_yumi_o, 1); step();
    clear_mem();

    // core 2 granted, then reset while in RESP
    push_grant(2);
    settle(); step();
    mem_yumi_i = 1'b1;
    settle(); step();
    mem_yumi_i = 1'b0; req_valid_i[2] = 1'b0;
    mem_valid_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF; reset = 1'b1;
    settle(); chk("t6_in_resp", resp_valid_o, 4'b0100); step();
    reset = 1'b0; mem_yumi_i = 1'b1; resp_yumi_i = '1;
    settle(); chk("t6_reset_zero", all_out, 0); step();
    clear_mem();
    // rr_ptr back at 0: core 1 wins over core 3
    set_req(1, 1'b0, 1'b0, 32'h111, 32'h0);
    set_req(3, 1'b1, 1'b1, 32'h333, 32'h77);
    do_txn(1, 32'h00000001, 0);
    do_txn(3, 32'h00000003, 0);

    settle();
    chk("queues_empty", gq.size() + rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
